alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised multi-cycle ALU for the datapath execute stage. Single-cycle ops cover add/sub/logic, signed and unsigned compare, and overflow-checked add. Iterative unsigned multiply (shift-add) and divide (restoring) complete in WIDTH cycles. A start/busy/done handshake lets the control unit stall while the iterative ops run.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
OP_W, 4, opcode width (encodings in alu_pkg)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  request; sampled only when busy=0
op  in  OP_W  operation, sampled with start
a  in  WIDTH  operand A, sampled with start
b  in  WIDTH  operand B, sampled with start
busy  out  1  iterative op in progress
done  out  1  one-cycle pulse: results valid
result  out  WIDTH  main result (sum, logic, slt, product low, quotient)
result_hi  out  WIDTH  product high / remainder; 0 for single-cycle ops
zero  out  1  result == 0
of  out  1  signed overflow (ADDO only, else 0)
div0  out  1  DIVU with b == 0

Behaviour:
- Reset (async, any time incl. mid-operation): state=IDLE, busy=0, done=0, result=0, result_hi=0, zero=0, of=0, div0=0; iteration lost.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 ADDO (signed add, of set), 7 SLTU, 8 MULU, 9 DIVU; 10-15 illegal -> result=0, result_hi=0, zero=1, single-cycle.
- All arithmetic modulo 2^WIDTH; ADDO of = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
- SLT: signed compare, correct for every sign combination (incl. both negative); result 1 or 0 zero-extended.
- Outputs are registered and held until the next accepted start or reset; done is high for exactly one cycle.
- start accepted at edge E0 when busy=0; start while busy=1 is ignored (no queueing).
- Single-cycle ops and illegal ops: outputs and done=1 visible after E0 (latency 1); state stays IDLE; back-to-back starts every cycle allowed.
- DIVU with b==0: single-cycle; result=all ones, result_hi=a, div0=1, zero=0.
- MULU / DIVU (b!=0): at E0 latch operands, counter=WIDTH-1, state->MUL or DIV, busy=1. One iteration per edge E1..E_WIDTH. At E_WIDTH: final step, outputs written, done=1, busy=0, state->IDLE. busy is high for exactly WIDTH cycles. A new start is accepted in the cycle done is high.
- MUL: 2*WIDTH-bit accumulator, shift-add on b's LSB; result=product[WIDTH-1:0], result_hi=product[2W-1:W].
- DIV: restoring, one quotient bit per cycle MSB first; result=quotient, result_hi=remainder.
- zero reflects result only (not result_hi); of=0 and div0=0 for every op except as stated.
- States: IDLE, MUL, DIV. MUL/DIV -> IDLE only on counter==0 or reset.

Decomposition:
- alu_pkg: op encoding localparams (OP_ADD..OP_DIVU), state enum (IDLE, MUL, DIV), OP_W.
- Sub-module alu_muldiv_seq: iterative engine (accumulator, counter, MUL/DIV step logic) with load/step/fin interface. alu_mc holds the single-cycle datapath, the FSM and the output registers.

Test Plan:
- ADDO a=0x7FFFFFFF b=0x00000001 -> next cycle done=1, result=0x80000000, of=1, zero=0; SUB a=5 b=5 -> result=0, zero=1, of=0.
- SLT a=0xFFFFFFFE b=0xFFFFFFFF -> 1; SLT a=0xFFFFFFFF b=1 -> 1; SLTU a=0xFFFFFFFF b=1 -> 0; op=12 -> result=0, zero=1.
- MULU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 32 cycles, done after E32, result=0x00000001, result_hi=0xFFFFFFFE; start pulsed at cycle 5 of busy is ignored.
- DIVU a=100 b=7 -> after 32 cycles result=14, result_hi=2; DIVU a=5 b=0 -> next cycle result=0xFFFFFFFF, result_hi=5, div0=1, busy never asserted.
- Reset asserted asynchronously on cycle 10 of MULU -> busy, done and all outputs 0 immediately. After release, ADD 3+4 -> result=7 one cycle later.
- Back-to-back: ADD, then MULU issued in the same cycle done is high, then AND -> each done pulse exactly one cycle, values correct, no lost starts.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings and FSM states.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd5;
  localparam logic [OP_W-1:0] OP_ADDO = 4'd6;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd7;
  localparam logic [OP_W-1:0] OP_MULU = 4'd8;
  localparam logic [OP_W-1:0] OP_DIVU = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the control unit (master) and the ALU (slave).
interface alu_mc_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W_IF = alu_pkg::OP_W
);
  // Handshake: the ALU accepts start (with op/a/b) on a rising edge where busy=0;
  // start while busy=1 is dropped. done pulses for one cycle when outputs are valid,
  // and outputs hold until the next accepted start.
  logic               start;
  logic [OP_W_IF-1:0] op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   result_hi;
  logic               zero;
  logic               of;
  logic               div0;

  modport master (
    output start, op, a, b,
    input  busy, done, result, result_hi, zero, of, div0
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, result_hi, zero, of, div0
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative engine: shift-add unsigned multiply and restoring unsigned divide,
// one step per cycle over a shared 2*WIDTH accumulator.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic               div_mode;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;

  // MUL: acc = {partial, multiplier}; DIV: acc = {remainder, dividend/quotient}.
  always_comb begin
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd};
    if (div_mode) begin
      if (!rem_diff[WIDTH]) acc_nxt = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_nxt = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
    end
  end

  assign res_lo = acc_nxt[WIDTH-1:0];
  assign res_hi = acc_nxt[2*WIDTH-1:WIDTH];
  assign fin    = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      acc      <= is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      opnd     <= is_div ? b : a;
      div_mode <= is_div;
      cnt      <= CNT_W'(WIDTH - 1);
    end else if (step) begin
      acc <= acc_nxt;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle datapath, IDLE/MUL/DIV control FSM and
// registered outputs; iterative ops are delegated to alu_muldiv_seq.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W_P = alu_pkg::OP_W
) (
  input  logic    clk,
  input  logic    rst,
  alu_mc_if.slave bus,
  output state_t  state_dbg
);

  state_t           state_q, state_d;
  logic             seq_load, seq_step, seq_fin;
  logic [WIDTH-1:0] seq_lo, seq_hi;

  logic [WIDTH-1:0] sc_res, sc_hi, sum;
  logic             sc_of, sc_div0;
  logic             wr;
  logic [WIDTH-1:0] wr_res, wr_hi;
  logic             wr_of, wr_div0;

  logic [WIDTH-1:0] result_q, result_hi_q;
  logic             done_q, zero_q, of_q, div0_q;

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clk    (clk),
    .rst    (rst),
    .load   (seq_load),
    .is_div (bus.op == OP_DIVU),
    .step   (seq_step),
    .a      (bus.a),
    .b      (bus.b),
    .fin    (seq_fin),
    .res_lo (seq_lo),
    .res_hi (seq_hi)
  );

  always_comb begin
    sum     = bus.a + bus.b;
    sc_res  = '0;
    sc_hi   = '0;
    sc_of   = 1'b0;
    sc_div0 = 1'b0;
    case (bus.op)
      OP_ADD:  sc_res = sum;
      OP_SUB:  sc_res = bus.a - bus.b;
      OP_AND:  sc_res = bus.a & bus.b;
      OP_OR:   sc_res = bus.a | bus.b;
      OP_XOR:  sc_res = bus.a ^ bus.b;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_ADDO: begin
        sc_res = sum;
        sc_of  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      // Only the divide-by-zero case reaches here as a single-cycle DIVU.
      OP_DIVU: begin
        sc_res  = '1;
        sc_hi   = bus.a;
        sc_div0 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    seq_load = 1'b0;
    seq_step = 1'b0;
    wr       = 1'b0;
    wr_res   = sc_res;
    wr_hi    = sc_hi;
    wr_of    = sc_of;
    wr_div0  = sc_div0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MULU) begin
            seq_load = 1'b1;
            state_d  = MUL;
          end else if (bus.op == OP_DIVU && bus.b != '0) begin
            seq_load = 1'b1;
            state_d  = DIV;
          end else begin
            wr = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        seq_step = 1'b1;
        if (seq_fin) begin
          wr      = 1'b1;
          wr_res  = seq_lo;
          wr_hi   = seq_hi;
          wr_of   = 1'b0;
          wr_div0 = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      of_q        <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      done_q <= wr;
      if (wr) begin
        result_q    <= wr_res;
        result_hi_q <= wr_hi;
        zero_q      <= (wr_res == '0);
        of_q        <= wr_of;
        div0_q      <= wr_div0;
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.zero      = zero_q;
  assign bus.of        = of_q;
  assign bus.div0      = div0_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         of;
    logic         div0;
  } out_t;

  logic   clk;
  logic   rst;
  state_t state_dbg;
  int     checks;
  int     errors;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    out_t        o;
    longint      s;
    logic [63:0] p;
    o = '0;
    case (op)
      4'd0: o.res = a + b;
      4'd1: o.res = a - b;
      4'd2: o.res = a & b;
      4'd3: o.res = a | b;
      4'd4: o.res = a ^ b;
      4'd5: o.res = (longint'($signed(a)) < longint'($signed(b))) ? 1 : 0;
      4'd6: begin
        s     = longint'($signed(a)) + longint'($signed(b));
        o.res = a + b;
        o.of  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: o.res = (a < b) ? 1 : 0;
      4'd8: begin
        p     = {32'd0, a} * {32'd0, b};
        o.res = p[31:0];
        o.hi  = p[63:32];
      end
      4'd9: begin
        if (b == 0) begin
          o.res  = '1;
          o.hi   = a;
          o.div0 = 1'b1;
        end else begin
          o.res = a / b;
          o.hi  = a % b;
        end
      end
      default: o = '0;
    endcase
    o.zero = (o.res == 0);
    return o;
  endfunction

  function automatic int exp_latency(input logic [3:0] op, input logic [W-1:0] b);
    return (op == 4'd8 || (op == 4'd9 && b != 0)) ? W + 1 : 1;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.res  = bus.result;
    o.hi   = bus.result_hi;
    o.zero = bus.zero;
    o.of   = bus.of;
    o.div0 = bus.div0;
    return o;
  endfunction

  // Issue one op and wait (bounded) for done; lat counts edges from acceptance to done.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_cnt, output out_t obs);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    obs = observe();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, observe()} !== '0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b out=%h state=%0d, want all 0 / IDLE",
               bus.busy, bus.done, observe(), state_dbg);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0] ops [10] = '{4'd6, 4'd1, 4'd5, 4'd5, 4'd7, 4'd12, 4'd9, 4'd9, 4'd8, 4'd0};
    logic [W-1:0] as [10] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h1234, 32'd100, 32'd5, 32'hFFFFFFFF, 32'd3};
    logic [W-1:0] bs [10] = '{32'h1, 32'd5, 32'hFFFFFFFF, 32'h1, 32'h1,
                             32'h5678, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd4};
    int   lat, bc;
    out_t obs, exp_o;
    for (int i = 0; i < 10; i++) begin
      do_op(ops[i], as[i], bs[i], lat, bc, obs);
      exp_o = model(ops[i], as[i], bs[i]);
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL directed_%0d op=%0d: got %h, want %h", i, ops[i], obs, exp_o);
      end
      checks++;
      if (lat !== exp_latency(ops[i], bs[i]) || bc !== exp_latency(ops[i], bs[i]) - 1) begin
        errors++;
        $display("FAIL directed_lat_%0d op=%0d: got lat=%0d busy=%0d, want lat=%0d",
                 i, ops[i], lat, bc, exp_latency(ops[i], bs[i]));
      end
    end
  endtask

  task automatic test_mul_ignore_start();
    int   lat, bc;
    out_t exp_o;
    exp_o = model(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd8; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1; bc = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) bc++;
      if (bc == 5) begin
        bus.start = 1'b1; bus.op = 4'd0; bus.a = 32'd1; bus.b = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    checks++;
    if (observe() !== exp_o || lat !== W + 1 || bc !== W) begin
      errors++;
      $display("FAIL mul_ignore: got out=%h lat=%0d busy=%0d, want out=%h lat=%0d busy=%0d",
               observe(), lat, bc, exp_o, W + 1, W);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || observe() !== exp_o) begin
      errors++;
      $display("FAIL mul_no_queue: got done=%b busy=%b out=%h, want done=0 busy=0 out=%h",
               bus.done, bus.busy, observe(), exp_o);
    end
  endtask

  task automatic test_reset_mid();
    int   lat, bc;
    out_t obs;
    do_op(4'd0, 32'd10, 32'd20, lat, bc, obs);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd8; bus.a = 32'h1234567; bus.b = 32'h89ABCDE;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, observe()} !== '0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b out=%h state=%0d, want all 0 / IDLE",
               bus.busy, bus.done, observe(), state_dbg);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(4'd0, 32'd3, 32'd4, lat, bc, obs);
    checks++;
    if (obs.res !== 32'd7 || lat !== 1) begin
      errors++;
      $display("FAIL after_reset_add: got res=%0d lat=%0d, want res=7 lat=1", obs.res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ma, mb;
    out_t exp_o;
    int   lat;
    ma = $urandom; mb = $urandom;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd0; bus.a = 32'd100; bus.b = 32'd23;
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b1 || bus.result !== 32'd123) begin
      errors++;
      $display("FAIL b2b_add: got done=%b res=%0d, want done=1 res=123", bus.done, bus.result);
    end
    bus.op = 4'd8; bus.a = ma; bus.b = mb;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_mul_accept: got done=%b busy=%b, want done=0 busy=1", bus.done, bus.busy);
    end
    lat = 1;
    while (!bus.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    exp_o = model(4'd8, ma, mb);
    checks++;
    if (observe() !== exp_o || lat !== W + 1) begin
      errors++;
      $display("FAIL b2b_mul: got out=%h lat=%0d, want out=%h lat=%0d", observe(), lat, exp_o, W + 1);
    end
    bus.start = 1'b1; bus.op = 4'd2; bus.a = ma; bus.b = mb;
    @(posedge clk); #1;
    bus.start = 1'b0;
    exp_o = model(4'd2, ma, mb);
    checks++;
    if (bus.done !== 1'b1 || observe() !== exp_o) begin
      errors++;
      $display("FAIL b2b_and: got done=%b out=%h, want done=1 out=%h", bus.done, observe(), exp_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_pulse: got done=%b, want 0", bus.done);
    end
  endtask

  task automatic test_random();
    logic [3:0]   op;
    logic [W-1:0] a, b;
    int           lat, bc;
    out_t         obs, exp_o;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = $urandom_range(0, 3);
        2: a = {1'b1, a[W-2:0]};
        default: ;
      endcase
      do_op(op, a, b, lat, bc, obs);
      exp_o = model(op, a, b);
      checks++;
      if (obs !== exp_o || lat !== exp_latency(op, b) || bc !== exp_latency(op, b) - 1) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got out=%h lat=%0d busy=%0d, want out=%h lat=%0d",
                 i, op, a, b, obs, lat, bc, exp_o, exp_latency(op, b));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_mul_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
